fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC generator feeding a small in-order fetch queue.
// Instructions are registered into the queue, so decode sees a fetch one cycle after it completes.
module fetch_unit #(
    parameter int                         INST_WIDTH      = 32,
    parameter int                         INST_ADDR_WIDTH = 32,
    parameter int                         FIFO_DEPTH      = 4,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                          cpu_clk,
    input  logic                          cpu_rst_n,
    output logic [INST_ADDR_WIDTH-1:0]    imem_addr,
    output logic                          imem_req,
    input  logic [INST_WIDTH-1:0]         imem_rdata,
    input  logic                          imem_hazard,
    input  logic                          redirect_valid,
    input  logic [INST_ADDR_WIDTH-1:0]    redirect_pc,
    output logic                          fetch_valid,
    input  logic                          fetch_ready,
    output logic [INST_ADDR_WIDTH-1:0]    fetch_pc,
    output logic [INST_ADDR_WIDTH-1:0]    fetch_pc_plus_4,
    output logic [INST_WIDTH-1:0]         fetch_inst,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [INST_ADDR_WIDTH-1:0] pc_q;
    logic [PW-1:0]              rd_ptr_q;
    logic [PW-1:0]              wr_ptr_q;
    logic [CW-1:0]              count_q;

    logic [INST_ADDR_WIDTH-1:0] mem_pc   [FIFO_DEPTH];
    logic [INST_WIDTH-1:0]      mem_inst [FIFO_DEPTH];

    logic                       full;
    logic                       accept;
    logic                       pop;
    logic [INST_ADDR_WIDTH-1:0] redirect_target;

    assign full            = (count_q == CW'(FIFO_DEPTH));
    assign pop             = fetch_valid & fetch_ready;
    assign redirect_target = redirect_pc & ~INST_ADDR_WIDTH'(3);

    // Reset only gates the request pin; state flops already ignore accept while in reset.
    assign imem_req  = cpu_rst_n & ~full;
    assign accept    = ~full & ~imem_hazard & ~redirect_valid;
    assign imem_addr = pc_q;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            pc_q     <= redirect_target;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                pc_q     <= pc_q + INST_ADDR_WIDTH'(4);
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (accept && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !accept) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Queue storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge cpu_clk) begin
        if (accept) begin
            mem_pc[wr_ptr_q]   <= pc_q;
            mem_inst[wr_ptr_q] <= imem_rdata;
        end
    end

    assign fetch_valid     = (count_q != '0);
    assign fetch_pc        = mem_pc[rd_ptr_q];
    assign fetch_inst      = mem_inst[rd_ptr_q];
    assign fetch_pc_plus_4 = fetch_pc + INST_ADDR_WIDTH'(4);
    assign fifo_count      = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a queue-based reference model.
// A second instance with RESET_PC near the top of the address space exercises PC wrap-around.
module tb_fetch_unit;
    localparam int DEPTH = 4;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    logic [31:0] imem_addr, imem_rdata, redirect_pc, fetch_pc, fetch_pc_plus_4, fetch_inst;
    logic        imem_req, imem_hazard, redirect_valid, fetch_valid, fetch_ready;
    logic [2:0]  fifo_count;

    logic [31:0] w_imem_addr, w_imem_rdata, w_redirect_pc, w_fetch_pc, w_fetch_pc_plus_4, w_fetch_inst;
    logic        w_imem_req, w_imem_hazard, w_redirect_valid, w_fetch_valid, w_fetch_ready;
    logic [2:0]  w_fifo_count;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign imem_rdata   = mem_fn(imem_addr);
    assign w_imem_rdata = mem_fn(w_imem_addr);

    fetch_unit #(.INST_WIDTH(32), .INST_ADDR_WIDTH(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_hazard(imem_hazard), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc), .fetch_pc_plus_4(fetch_pc_plus_4), .fetch_inst(fetch_inst),
        .fifo_count(fifo_count)
    );

    fetch_unit #(.INST_WIDTH(32), .INST_ADDR_WIDTH(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'hFFFFFFFC)) dut_w (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .imem_addr(w_imem_addr), .imem_req(w_imem_req),
        .imem_rdata(w_imem_rdata), .imem_hazard(w_imem_hazard), .redirect_valid(w_redirect_valid),
        .redirect_pc(w_redirect_pc), .fetch_valid(w_fetch_valid), .fetch_ready(w_fetch_ready),
        .fetch_pc(w_fetch_pc), .fetch_pc_plus_4(w_fetch_pc_plus_4), .fetch_inst(w_fetch_inst),
        .fifo_count(w_fifo_count)
    );

    // Reference model: the queue as a list of (pc, inst) pairs plus the next fetch address.
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];
    logic [31:0] m_pc;
    int n_cmp = 0;
    int n_fail = 0;

    task automatic model_clear();
        q_pc.delete();
        q_inst.delete();
        m_pc = 32'h0;
    endtask

    task automatic step(input logic hz, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic acc, pp;
        imem_hazard    = hz;
        redirect_valid = rv;
        redirect_pc    = rpc;
        fetch_ready    = rdy;
        @(posedge cpu_clk);
        acc = (q_pc.size() < DEPTH) && !hz && !rv;
        pp  = (q_pc.size() != 0) && rdy;
        if (rv) begin
            q_pc.delete();
            q_inst.delete();
            m_pc = rpc & 32'hFFFFFFFC;
        end else begin
            if (pp) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            if (acc) begin
                q_pc.push_back(m_pc);
                q_inst.push_back(mem_fn(m_pc));
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge cpu_clk);
    endtask

    task automatic reset_dut();
        @(negedge cpu_clk);
        imem_hazard = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; fetch_ready = 1'b0;
        cpu_rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge cpu_clk);
        imem_hazard = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; fetch_ready = 1'b1;
        cpu_rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge cpu_clk);
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0h want 0", imem_req); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", fetch_valid); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", imem_addr); end
        cpu_rst_n = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_first_req: got %0h want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_first_addr: got %0h want 0", imem_addr); end
    endtask

    task automatic test_streaming();
        reset_dut();
        n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c1_valid: got %0h want 0", fetch_valid); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            n_cmp++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %0h want 1", i, fetch_valid); end
            n_cmp++; if (fetch_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %0h want %0h", i, fetch_pc, 4 * i); end
            n_cmp++; if (fetch_inst !== mem_fn(32'(4 * i))) begin n_fail++; $display("FAIL stream_inst[%0d]: got %0h want %0h", i, fetch_inst, mem_fn(32'(4 * i))); end
            n_cmp++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d want 1", i, fifo_count); end
        end
    endtask

    task automatic test_fill_full();
        reset_dut();
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req: got %0h want 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL full_addr: got %0h want 10", imem_addr); end
        n_cmp++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL full_head_hold: got %0h want 0", fetch_pc); end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count: got %0d want 3", fifo_count); end
        n_cmp++; if (fetch_pc !== 32'h4) begin n_fail++; $display("FAIL full_pop_head: got %0h want 4", fetch_pc); end
        n_cmp++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL full_pop_addr: got %0h want 10", imem_addr); end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_refill_count: got %0d want 4", fifo_count); end
        n_cmp++; if (imem_addr !== 32'h14) begin n_fail++; $display("FAIL full_refill_addr: got %0h want 14", imem_addr); end
    endtask

    task automatic test_wait_states();
        reset_dut();
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            n_cmp++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL wait_addr[%0d]: got %0h want 8", i, imem_addr); end
            n_cmp++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL wait_count[%0d]: got %0d want 2", i, fifo_count); end
            n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req[%0d]: got %0h want 1", i, imem_req); end
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL wait_done_count: got %0d want 3", fifo_count); end
        n_cmp++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL wait_done_addr: got %0h want c", imem_addr); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (fetch_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL wait_drain_pc[%0d]: got %0h want %0h", i, fetch_pc, 4 * i); end
            step(1'b1, 1'b0, 32'h0, 1'b1);
        end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL wait_drain_empty: got %0h want 0", fetch_valid); end
    endtask

    task automatic test_redirect();
        reset_dut();
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h103, 1'b0);
        n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL redir_count: got %0d want 0", fifo_count); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %0h want 0", fetch_valid); end
        n_cmp++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr: got %0h want 100", imem_addr); end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++; if (fetch_pc !== 32'h100) begin n_fail++; $display("FAIL redir_head_pc: got %0h want 100", fetch_pc); end
        n_cmp++; if (fetch_pc_plus_4 !== 32'h104) begin n_fail++; $display("FAIL redir_head_pc4: got %0h want 104", fetch_pc_plus_4); end
        n_cmp++; if (fetch_inst !== mem_fn(32'h100)) begin n_fail++; $display("FAIL redir_head_inst: got %0h want %0h", fetch_inst, mem_fn(32'h100)); end
        step(1'b0, 1'b1, 32'h202, 1'b1);
        n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL redir_pop_count: got %0d want 0", fifo_count); end
        n_cmp++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL redir_pop_addr: got %0h want 200", imem_addr); end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h30B, 1'b0);
        n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL redir_hz_count: got %0d want 0", fifo_count); end
        n_cmp++; if (imem_addr !== 32'h308) begin n_fail++; $display("FAIL redir_hz_addr: got %0h want 308", imem_addr); end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
        imem_hazard = 1'b1;
        @(posedge cpu_clk);
        #2;
        cpu_rst_n = 1'b0;
        model_clear();
        #1;
        n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", fifo_count); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0h want 0", fetch_valid); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_addr: got %0h want 0", imem_addr); end
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %0h want 0", imem_req); end
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_rel_req: got %0h want 1", imem_req); end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL midrst_after_count: got %0d want 1", fifo_count); end
        n_cmp++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_after_pc: got %0h want 0", fetch_pc); end
    endtask

    task automatic test_random();
        logic hz, rv, rdy;
        logic [31:0] rpc;
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            hz  = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            rpc = ($urandom_range(0, 2) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step(hz, rv, rpc, rdy);
            n_cmp++; if (imem_req !== (q_pc.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_req[%0d]: got %0h want %0h", i, imem_req, q_pc.size() < DEPTH); end
            n_cmp++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %0h want %0h", i, imem_addr, m_pc); end
            n_cmp++; if (fifo_count !== 3'(q_pc.size())) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, fifo_count, q_pc.size()); end
            n_cmp++; if (fetch_valid !== (q_pc.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0h want %0h", i, fetch_valid, q_pc.size() != 0); end
            if (q_pc.size() != 0) begin
                n_cmp++; if (fetch_pc !== q_pc[0]) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %0h want %0h", i, fetch_pc, q_pc[0]); end
                n_cmp++; if (fetch_pc_plus_4 !== q_pc[0] + 32'd4) begin n_fail++; $display("FAIL rnd_pc4[%0d]: got %0h want %0h", i, fetch_pc_plus_4, q_pc[0] + 32'd4); end
                n_cmp++; if (fetch_inst !== q_inst[0]) begin n_fail++; $display("FAIL rnd_inst[%0d]: got %0h want %0h", i, fetch_inst, q_inst[0]); end
            end
        end
    endtask

    task automatic test_wrap();
        @(negedge cpu_clk);
        cpu_rst_n = 1'b0;
        #1;
        n_cmp++; if (w_imem_addr !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_rst_addr: got %0h want fffffffc", w_imem_addr); end
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        #1;
        n_cmp++; if (w_imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_first_req: got %0h want 1", w_imem_req); end
        @(negedge cpu_clk);
        n_cmp++; if (w_fetch_pc !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_head_pc: got %0h want fffffffc", w_fetch_pc); end
        n_cmp++; if (w_fetch_pc_plus_4 !== 32'h0) begin n_fail++; $display("FAIL wrap_head_pc4: got %0h want 0", w_fetch_pc_plus_4); end
        n_cmp++; if (w_imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %0h want 0", w_imem_addr); end
        @(negedge cpu_clk);
        n_cmp++; if (w_fetch_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_next_pc: got %0h want 0", w_fetch_pc); end
        n_cmp++; if (w_fetch_inst !== mem_fn(32'h0)) begin n_fail++; $display("FAIL wrap_next_inst: got %0h want %0h", w_fetch_inst, mem_fn(32'h0)); end
    endtask

    initial begin
        imem_hazard = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; fetch_ready = 1'b0;
        w_imem_hazard = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = 32'h0; w_fetch_ready = 1'b1;
        model_clear();
        test_reset();
        test_streaming();
        test_fill_full();
        test_wait_states();
        test_redirect();
        test_mid_reset();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
